reg_file_sb: RTL and testbench

- Parametrised multi-port architectural register file with a per-register busy scoreboard.
- Next generation of the 32x64 register array: configurable width, depth and port counts.
- Adds combinational write-to-read bypass, a hardwired zero register and producer tracking (claim/clear) for the issue stage.
- Sits between decode/issue, which reads operands and claims destinations, and writeback, which writes results and clears busy bits.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/reg_slot.sv | 38 +++
 rtl/reg_file_sb.sv | 106 ++++++++++
 tb/tb_reg_file_sb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and index/data types for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ZERO_REG = 31;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_slot.sv
// One architectural register: data word plus its scoreboard busy bit.
module reg_slot
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              claim_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);

    logic [DATA_W-1:0] data_q;
    logic              busy_q;

    // NOTE: every slot is reset because never-written registers must read 0;
    // this keeps the array in flops rather than a RAM macro without reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            if (we_i) data_q <= wdata_i;
            // A new producer supersedes the one writing back this cycle.
            if (claim_i)      busy_q <= 1'b1;
            else if (clear_i) busy_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-to-read bypass, hardwired zero register
// and a per-register busy scoreboard for producer tracking.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
    input  logic                           claim_en,
    input  logic [ADDR_W-1:0]              claim_addr,
    output logic [NUM_REGS-1:0]            busy_vec,
    output logic                           conflict
);

    localparam logic [ADDR_W-1:0] ZERO_IDX   = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]   reg_data [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                conflict_d, conflict_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
        if (g == ZERO_REG) begin : g_zero
            assign reg_data[g] = '0;
            assign busy[g]     = 1'b0;
        end else begin : g_live
            logic              we;
            logic [DATA_W-1:0] wdata;
            logic              claim;

            // Ascending scan so the highest-numbered matching port wins.
            // NOTE: defaults assigned first so no path leaves a latch.
            always_comb begin
                we    = 1'b0;
                wdata = '0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && wr_addr[p] == ADDR_W'(g)) begin
                        we    = 1'b1;
                        wdata = wr_data[p];
                    end
                end
            end

            assign claim = claim_en && (claim_addr == ADDR_W'(g));

            reg_slot #(.DATA_W(DATA_W)) u_slot (
                .clk     (clk),
                .rst_n   (reset),
                .we_i    (we),
                .wdata_i (wdata),
                .claim_i (claim),
                .clear_i (we),
                .data_o  (reg_data[g]),
                .busy_o  (busy[g])
            );
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data[r] = '0;
            rd_busy[r] = 1'b0;
            if ({1'b0, rd_addr[r]} < NUM_REGS_W && rd_addr[r] != ZERO_IDX) begin
                rd_data[r] = reg_data[rd_addr[r]];
                rd_busy[r] = busy[rd_addr[r]];
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && wr_addr[p] == rd_addr[r]) begin
                        rd_data[r] = wr_data[p];
                        rd_busy[r] = 1'b0;
                    end
                end
            end
        end
    end

    // Any pair of enabled ports on one index, zero register included.
    always_comb begin
        conflict_d = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            for (int q = p + 1; q < NUM_WR; q++) begin
                if (wr_en[p] && wr_en[q] && wr_addr[p] == wr_addr[q]) conflict_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) conflict_q <= 1'b0;
        else        conflict_q <= conflict_d;
    end

    assign busy_vec = busy;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised and directed bench for reg_file_sb against an array-based model.
module tb_reg_file_sb;
    import regfile_pkg::*;

    logic                  clk;
    logic                  reset;
    reg_idx_t  [1:0]       rd_addr;
    reg_data_t [1:0]       rd_data;
    logic      [1:0]       rd_busy;
    logic      [1:0]       wr_en;
    reg_idx_t  [1:0]       wr_addr;
    reg_data_t [1:0]       wr_data;
    logic                  claim_en;
    reg_idx_t              claim_addr;
    logic      [31:0]      busy_vec;
    logic                  conflict;

    int total = 0;
    int bad   = 0;

    reg_data_t   m_regs [32];
    logic [31:0] m_busy;
    logic        m_conflict;

    reg_file_sb dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy_vec   (busy_vec),
        .conflict   (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy     = '0;
        m_conflict = 1'b0;
    endfunction

    // Expected combinational read for an index under the current write inputs.
    function automatic void exp_read(input int a, output reg_data_t d, output logic b);
        d = '0;
        b = 1'b0;
        if (a != 31) begin
            d = m_regs[a];
            b = m_busy[a];
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && int'(wr_addr[p]) == a) begin
                    d = wr_data[p];
                    b = 1'b0;
                end
            end
        end
    endfunction

    // Advance the model by one edge from the current inputs, then clock the DUT.
    task automatic step();
        logic [31:0] written;
        written    = '0;
        m_conflict = wr_en[0] && wr_en[1] && (wr_addr[0] == wr_addr[1]);
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                written[wr_addr[p]] = 1'b1;
                if (wr_addr[p] != 5'd31) m_regs[wr_addr[p]] = wr_data[p];
            end
        end
        for (int i = 0; i < 31; i++) begin
            if (claim_en && int'(claim_addr) == i) m_busy[i] = 1'b1;
            else if (written[i])                   m_busy[i] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        rd_addr = '0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy_vec !== 32'h0) begin bad++; $display("FAIL reset_busy_vec got=%h exp=0", busy_vec); end
        total++;
        if (conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b exp=0", conflict); end
        reset = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd_addr[0] = reg_idx_t'(a);
            rd_addr[1] = reg_idx_t'(31 - a);
            #1;
            total++;
            if (rd_data !== '0 || rd_busy !== 2'b00) begin
                bad++;
                $display("FAIL reset_read idx=%0d got=%h/%h busy=%b exp=0", a, rd_data[0], rd_data[1], rd_busy);
            end
        end
        // Reset asserted in the middle of a write cycle discards the write.
        @(posedge clk);
        #1;
        wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 64'hDEAD;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle();
        reset = 1'b1;
        model_clear();
        rd_addr[0] = 5'd5;
        #1;
        total++;
        if (rd_data[0] !== 64'h0) begin bad++; $display("FAIL reset_mid_write got=%h exp=0", rd_data[0]); end
    endtask

    task automatic test_bypass();
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 64'h1F;
        rd_addr[0] = 5'd3;
        #1;
        total++;
        if (rd_data[0] !== 64'h1F) begin bad++; $display("FAIL bypass_same_cycle got=%h exp=1f", rd_data[0]); end
        step();
        idle();
        #1;
        total++;
        if (rd_data[0] !== 64'h1F) begin bad++; $display("FAIL bypass_stored got=%h exp=1f", rd_data[0]); end
    endtask

    task automatic test_conflict();
        idle();
        wr_en = 2'b11;
        wr_addr[0] = 5'd7; wr_data[0] = 64'hAAAA;
        wr_addr[1] = 5'd7; wr_data[1] = 64'h5555;
        rd_addr[1] = 5'd7;
        #1;
        total++;
        if (rd_data[1] !== 64'h5555) begin bad++; $display("FAIL conflict_bypass got=%h exp=5555", rd_data[1]); end
        step();
        idle();
        #1;
        total++;
        if (conflict !== 1'b1) begin bad++; $display("FAIL conflict_pulse got=%b exp=1", conflict); end
        total++;
        if (rd_data[1] !== 64'h5555) begin bad++; $display("FAIL conflict_stored got=%h exp=5555", rd_data[1]); end
        step();
        total++;
        if (conflict !== 1'b0) begin bad++; $display("FAIL conflict_drop got=%b exp=0", conflict); end
    endtask

    task automatic test_claim();
        idle();
        claim_en = 1'b1; claim_addr = 5'd10;
        rd_addr[0] = 5'd10;
        step();
        idle();
        #1;
        total++;
        if (busy_vec[10] !== 1'b1 || rd_busy[0] !== 1'b1) begin
            bad++; $display("FAIL claim_set busy_vec=%b rd_busy=%b exp=1/1", busy_vec[10], rd_busy[0]);
        end
        wr_en[0] = 1'b1; wr_addr[0] = 5'd10; wr_data[0] = 64'h42;
        #1;
        total++;
        if (rd_busy[0] !== 1'b0 || rd_data[0] !== 64'h42) begin
            bad++; $display("FAIL claim_wb_bypass rd_busy=%b data=%h exp=0/42", rd_busy[0], rd_data[0]);
        end
        step();
        idle();
        total++;
        if (busy_vec[10] !== 1'b0) begin bad++; $display("FAIL claim_cleared got=%b exp=0", busy_vec[10]); end
    endtask

    task automatic test_claim_write();
        idle();
        claim_en = 1'b1; claim_addr = 5'd12;
        wr_en[1] = 1'b1; wr_addr[1] = 5'd12; wr_data[1] = 64'h7;
        step();
        idle();
        rd_addr[0] = 5'd12;
        #1;
        total++;
        if (busy_vec[12] !== 1'b1) begin bad++; $display("FAIL claim_wins busy got=%b exp=1", busy_vec[12]); end
        total++;
        if (rd_data[0] !== 64'h7 || rd_busy[0] !== 1'b1) begin
            bad++; $display("FAIL claim_wins read data=%h busy=%b exp=7/1", rd_data[0], rd_busy[0]);
        end
    endtask

    task automatic test_zero_sweep();
        idle();
        wr_en[1] = 1'b1; wr_addr[1] = 5'd31; wr_data[1] = 64'hFFFF;
        claim_en = 1'b1; claim_addr = 5'd31;
        rd_addr[0] = 5'd31;
        #1;
        total++;
        if (rd_data[0] !== 64'h0 || rd_busy[0] !== 1'b0) begin
            bad++; $display("FAIL zero_bypass data=%h busy=%b exp=0/0", rd_data[0], rd_busy[0]);
        end
        step();
        idle();
        #1;
        total++;
        if (busy_vec[31] !== 1'b0 || rd_data[0] !== 64'h0) begin
            bad++; $display("FAIL zero_stored busy=%b data=%h exp=0/0", busy_vec[31], rd_data[0]);
        end
        for (int a = 0; a < 31; a++) begin
            wr_en = 2'b01; wr_addr[0] = reg_idx_t'(a); wr_data[0] = 64'h1F;
            step();
        end
        idle();
        for (int a = 0; a < 31; a++) begin
            rd_addr[0] = reg_idx_t'(a);
            rd_addr[1] = reg_idx_t'(30 - a);
            #1;
            total++;
            if (rd_data[0] !== 64'h1F || rd_data[1] !== 64'h1F) begin
                bad++; $display("FAIL sweep idx=%0d got=%h/%h exp=1f", a, rd_data[0], rd_data[1]);
            end
        end
    endtask

    task automatic test_random();
        reg_data_t ed;
        logic      eb;
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < 2; p++) begin
                wr_en[p]   = 1'($urandom_range(0, 1));
                wr_addr[p] = reg_idx_t'(c[0] ? $urandom_range(0, 3) : $urandom_range(0, 31));
                wr_data[p] = {$urandom, $urandom};
                rd_addr[p] = reg_idx_t'(c[1] ? $urandom_range(0, 3) : $urandom_range(0, 31));
            end
            claim_en   = 1'($urandom_range(0, 1));
            claim_addr = reg_idx_t'(c[2] ? $urandom_range(0, 3) : $urandom_range(0, 31));
            #1;
            for (int r = 0; r < 2; r++) begin
                exp_read(int'(rd_addr[r]), ed, eb);
                total++;
                if (rd_data[r] !== ed || rd_busy[r] !== eb) begin
                    bad++;
                    $display("FAIL rand_read cyc=%0d port=%0d idx=%0d got=%h/%b exp=%h/%b",
                             c, r, rd_addr[r], rd_data[r], rd_busy[r], ed, eb);
                end
            end
            step();
            total++;
            if (busy_vec !== m_busy || conflict !== m_conflict) begin
                bad++;
                $display("FAIL rand_state cyc=%0d busy=%h conflict=%b exp=%h/%b",
                         c, busy_vec, conflict, m_busy, m_conflict);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_conflict();
        test_claim();
        test_claim_write();
        test_zero_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
